// File: rtl/rs_station.sv
// rs_station: reservation station that buffers issued ALU/branch ops until
// both operands are valid. It snoops the CDB for operand values and
// dispatches one ready op per cycle to the ALU, choosing the lowest-index
// ready slot first.
module rs_station #(
  parameter int RS_DEPTH = 8,
  parameter int IDX_W    = 3,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int OP_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_rollback,
  input  logic              in_issue_ena,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_operand1,
  input  logic [DATA_W-1:0] in_operand2,
  input  logic [TAG_W-1:0]  in_tag1,
  input  logic [TAG_W-1:0]  in_tag2,
  input  logic [DATA_W-1:0] in_current_pc,
  input  logic [TAG_W-1:0]  in_dest_tag,
  input  logic              in_predicted_taken,
  output logic              out_full,
  input  logic              in_cdb_valid,
  input  logic [TAG_W-1:0]  in_cdb_tag,
  input  logic [DATA_W-1:0] in_cdb_value,
  output logic              out_alu_ena,
  output logic [OP_W-1:0]   out_alu_op,
  output logic [DATA_W-1:0] out_alu_operand1,
  output logic [DATA_W-1:0] out_alu_operand2,
  output logic [DATA_W-1:0] out_alu_imm,
  output logic [DATA_W-1:0] out_alu_pc,
  output logic [TAG_W-1:0]  out_alu_dest_tag,
  output logic              out_alu_predicted_taken
);

  logic [RS_DEPTH-1:0] busy;
  logic [OP_W-1:0]     slot_op   [RS_DEPTH];
  logic [DATA_W-1:0]   slot_imm  [RS_DEPTH];
  logic [DATA_W-1:0]   slot_opd1 [RS_DEPTH];
  logic [DATA_W-1:0]   slot_opd2 [RS_DEPTH];
  logic [TAG_W-1:0]    slot_tag1 [RS_DEPTH];
  logic [TAG_W-1:0]    slot_tag2 [RS_DEPTH];
  logic [DATA_W-1:0]   slot_pc   [RS_DEPTH];
  logic [TAG_W-1:0]    slot_dest [RS_DEPTH];
  logic [RS_DEPTH-1:0] slot_pred;

  logic [RS_DEPTH-1:0] ready;
  logic                have_ready;
  logic                have_free;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    free_idx;
  logic                do_issue;
  logic                do_dispatch;
  logic [DATA_W-1:0]   issue_opd1;
  logic [DATA_W-1:0]   issue_opd2;
  logic [TAG_W-1:0]    issue_tag1;
  logic [TAG_W-1:0]    issue_tag2;

  assign out_full    = &busy;
  assign do_issue    = in_issue_ena && have_free && !in_rollback;
  assign do_dispatch = have_ready && !in_rollback;

  // Ready vector from registered state only; a same-edge CDB capture is seen next cycle
  always_comb begin
    ready = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready[i] = busy[i] && (slot_tag1[i] == '0) && (slot_tag2[i] == '0);
    end
  end

  // Lowest-index ready slot for dispatch and lowest-index free slot for issue
  always_comb begin
    have_ready = 1'b0;
    sel_idx    = '0;
    have_free  = 1'b0;
    free_idx   = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        have_ready = 1'b1;
        sel_idx    = IDX_W'(i);
      end
      if (!busy[i]) begin
        have_free = 1'b1;
        free_idx  = IDX_W'(i);
      end
    end
  end

  // Issue-time bypass: a CDB broadcast on the issue edge satisfies the operand directly
  always_comb begin
    issue_opd1 = in_operand1;
    issue_tag1 = in_tag1;
    issue_opd2 = in_operand2;
    issue_tag2 = in_tag2;
    if (in_cdb_valid && (in_tag1 != '0) && (in_tag1 == in_cdb_tag)) begin
      issue_opd1 = in_cdb_value;
      issue_tag1 = '0;
    end
    if (in_cdb_valid && (in_tag2 != '0) && (in_tag2 == in_cdb_tag)) begin
      issue_opd2 = in_cdb_value;
      issue_tag2 = '0;
    end
  end

  // Busy bits: rollback flushes everything; dispatch frees a slot, issue claims another
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (in_rollback) begin
      busy <= '0;
    end else begin
      if (do_dispatch) busy[sel_idx] <= 1'b0;
      if (do_issue) busy[free_idx] <= 1'b1;
    end
  end

  // Slot payload: written on issue, operands captured from the CDB while waiting
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (do_issue && (free_idx == IDX_W'(i))) begin
        slot_op[i]   <= in_op;
        slot_imm[i]  <= in_imm;
        slot_opd1[i] <= issue_opd1;
        slot_opd2[i] <= issue_opd2;
        slot_tag1[i] <= issue_tag1;
        slot_tag2[i] <= issue_tag2;
        slot_pc[i]   <= in_current_pc;
        slot_dest[i] <= in_dest_tag;
        slot_pred[i] <= in_predicted_taken;
      end else if (busy[i] && in_cdb_valid) begin
        if ((slot_tag1[i] != '0) && (slot_tag1[i] == in_cdb_tag)) begin
          slot_opd1[i] <= in_cdb_value;
          slot_tag1[i] <= '0;
        end
        if ((slot_tag2[i] != '0) && (slot_tag2[i] == in_cdb_tag)) begin
          slot_opd2[i] <= in_cdb_value;
          slot_tag2[i] <= '0;
        end
      end
    end
  end

  // Dispatch register: pulses ena for one cycle, payload holds when nothing dispatches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_alu_ena             <= 1'b0;
      out_alu_op              <= '0;
      out_alu_operand1        <= '0;
      out_alu_operand2        <= '0;
      out_alu_imm             <= '0;
      out_alu_pc              <= '0;
      out_alu_dest_tag        <= '0;
      out_alu_predicted_taken <= 1'b0;
    end else if (do_dispatch) begin
      out_alu_ena             <= 1'b1;
      out_alu_op              <= slot_op[sel_idx];
      out_alu_operand1        <= slot_opd1[sel_idx];
      out_alu_operand2        <= slot_opd2[sel_idx];
      out_alu_imm             <= slot_imm[sel_idx];
      out_alu_pc              <= slot_pc[sel_idx];
      out_alu_dest_tag        <= slot_dest[sel_idx];
      out_alu_predicted_taken <= slot_pred[sel_idx];
    end else begin
      out_alu_ena <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// tb_rs_station: directed bench for rs_station with a slot-list reference
// model updated each edge and compared against the DUT every cycle.
module tb_rs_station;

  logic        clk;
  logic        rst;
  logic        in_rollback;
  logic        in_issue_ena;
  logic [5:0]  in_op;
  logic [31:0] in_imm;
  logic [31:0] in_operand1;
  logic [31:0] in_operand2;
  logic [3:0]  in_tag1;
  logic [3:0]  in_tag2;
  logic [31:0] in_current_pc;
  logic [3:0]  in_dest_tag;
  logic        in_predicted_taken;
  logic        out_full;
  logic        in_cdb_valid;
  logic [3:0]  in_cdb_tag;
  logic [31:0] in_cdb_value;
  logic        out_alu_ena;
  logic [5:0]  out_alu_op;
  logic [31:0] out_alu_operand1;
  logic [31:0] out_alu_operand2;
  logic [31:0] out_alu_imm;
  logic [31:0] out_alu_pc;
  logic [3:0]  out_alu_dest_tag;
  logic        out_alu_predicted_taken;

  int checks;
  int errors;

  rs_station dut (
    .clk(clk), .rst(rst), .in_rollback(in_rollback), .in_issue_ena(in_issue_ena),
    .in_op(in_op), .in_imm(in_imm), .in_operand1(in_operand1), .in_operand2(in_operand2),
    .in_tag1(in_tag1), .in_tag2(in_tag2), .in_current_pc(in_current_pc),
    .in_dest_tag(in_dest_tag), .in_predicted_taken(in_predicted_taken),
    .out_full(out_full), .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag),
    .in_cdb_value(in_cdb_value), .out_alu_ena(out_alu_ena), .out_alu_op(out_alu_op),
    .out_alu_operand1(out_alu_operand1), .out_alu_operand2(out_alu_operand2),
    .out_alu_imm(out_alu_imm), .out_alu_pc(out_alu_pc),
    .out_alu_dest_tag(out_alu_dest_tag), .out_alu_predicted_taken(out_alu_predicted_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a list of waiting ops plus the last dispatched op
  typedef struct {
    logic        busy;
    logic [5:0]  op;
    logic [31:0] imm, v1, v2, pc;
    logic [3:0]  t1, t2, dest;
    logic        pred;
  } entry_t;

  entry_t      m [8];
  logic        eEna;
  logic [5:0]  eOp;
  logic [31:0] eV1, eV2, eImm, ePc;
  logic [3:0]  eDest;
  logic        ePred;
  logic        issueWhileFull;
  int          mSel, mFree;
  bit          mFull;

  // Model update on each edge, using the slot list as it was before the edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
      eEna = 0; eOp = 0; eV1 = 0; eV2 = 0; eImm = 0; ePc = 0; eDest = 0; ePred = 0;
      issueWhileFull = 1'b0;
    end else begin
      mSel = -1; mFree = -1; mFull = 1'b1;
      for (int i = 7; i >= 0; i--) begin
        if (m[i].busy && m[i].t1 == 0 && m[i].t2 == 0) mSel = i;
        if (!m[i].busy) begin mFree = i; mFull = 1'b0; end
      end
      if (in_issue_ena && mFull && !in_rollback) issueWhileFull = 1'b1;
      if (in_rollback) begin
        for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
        eEna = 1'b0;
      end else begin
        if (mSel >= 0) begin
          eEna = 1'b1; eOp = m[mSel].op; eV1 = m[mSel].v1; eV2 = m[mSel].v2;
          eImm = m[mSel].imm; ePc = m[mSel].pc; eDest = m[mSel].dest; ePred = m[mSel].pred;
          m[mSel].busy = 1'b0;
        end else begin
          eEna = 1'b0;
        end
        if (in_cdb_valid) begin
          for (int i = 0; i < 8; i++) begin
            if (m[i].busy && m[i].t1 != 0 && m[i].t1 == in_cdb_tag) begin m[i].v1 = in_cdb_value; m[i].t1 = 0; end
            if (m[i].busy && m[i].t2 != 0 && m[i].t2 == in_cdb_tag) begin m[i].v2 = in_cdb_value; m[i].t2 = 0; end
          end
        end
        if (in_issue_ena && mFree >= 0) begin
          m[mFree].busy = 1'b1; m[mFree].op = in_op; m[mFree].imm = in_imm;
          m[mFree].pc = in_current_pc; m[mFree].dest = in_dest_tag; m[mFree].pred = in_predicted_taken;
          m[mFree].v1 = in_operand1; m[mFree].t1 = in_tag1;
          m[mFree].v2 = in_operand2; m[mFree].t2 = in_tag2;
          if (in_cdb_valid && in_tag1 != 0 && in_tag1 == in_cdb_tag) begin m[mFree].v1 = in_cdb_value; m[mFree].t1 = 0; end
          if (in_cdb_valid && in_tag2 != 0 && in_tag2 == in_cdb_tag) begin m[mFree].v2 = in_cdb_value; m[mFree].t2 = 0; end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic compareAll();
    logic eFull;
    eFull = 1'b1;
    for (int i = 0; i < 8; i++) if (!m[i].busy) eFull = 1'b0;
    checkOutput("model_full", out_full, eFull);
    checkOutput("model_ena", out_alu_ena, eEna);
    checkOutput("model_op", out_alu_op, eOp);
    checkOutput("model_opd1", out_alu_operand1, eV1);
    checkOutput("model_opd2", out_alu_operand2, eV2);
    checkOutput("model_imm", out_alu_imm, eImm);
    checkOutput("model_pc", out_alu_pc, ePc);
    checkOutput("model_dest", out_alu_dest_tag, eDest);
    checkOutput("model_pred", out_alu_predicted_taken, ePred);
    checkOutput("issue_not_full", issueWhileFull, 1'b0);
  endtask

  task automatic compareLoop();
    forever begin
      @(negedge clk);
      compareAll();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic ena, input logic [5:0] op,
                               input logic [3:0] t1, input logic [31:0] v1,
                               input logic [3:0] t2, input logic [31:0] v2,
                               input logic [3:0] dest, input logic [31:0] pc,
                               input logic [31:0] imm, input logic pred);
    in_issue_ena = ena; in_op = op; in_tag1 = t1; in_operand1 = v1;
    in_tag2 = t2; in_operand2 = v2; in_dest_tag = dest; in_current_pc = pc;
    in_imm = imm; in_predicted_taken = pred;
  endtask

  task automatic setCdb(input logic valid, input logic [3:0] tag, input logic [31:0] value);
    in_cdb_valid = valid; in_cdb_tag = tag; in_cdb_value = value;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 6'h0, 4'h0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
    setCdb(1'b0, 4'h0, 32'h0);
    in_rollback = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle();
    fork
      compareLoop();
    join_none
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_full", out_full, 1'b0);
    checkOutput("reset_ena", out_alu_ena, 1'b0);
    rst = 1'b0;
    step();

    $display("[TB] test 1: ready op dispatches one edge after issue");
    applyStimulus(1'b1, 6'h01, 4'h0, 32'd5, 4'h0, 32'd7, 4'h2, 32'h1000, 32'h0, 1'b0);
    step();
    idle();
    checkOutput("t1_not_yet", out_alu_ena, 1'b0);
    step();
    checkOutput("t1_ena", out_alu_ena, 1'b1);
    checkOutput("t1_opd1", out_alu_operand1, 32'd5);
    checkOutput("t1_opd2", out_alu_operand2, 32'd7);
    checkOutput("t1_dest", out_alu_dest_tag, 4'h2);
    checkOutput("t1_pc", out_alu_pc, 32'h1000);
    step();
    checkOutput("t1_pulse", out_alu_ena, 1'b0);
    checkOutput("t1_hold", out_alu_operand1, 32'd5);

    $display("[TB] test 2: wake-up from CDB");
    applyStimulus(1'b1, 6'h02, 4'h3, 32'hDEAD, 4'h0, 32'd1, 4'h4, 32'h1004, 32'h10, 1'b1);
    step();
    idle();
    step();
    step();
    setCdb(1'b1, 4'h3, 32'h100);
    step();
    checkOutput("t2_wait", out_alu_ena, 1'b0);
    idle();
    step();
    checkOutput("t2_ena", out_alu_ena, 1'b1);
    checkOutput("t2_opd1", out_alu_operand1, 32'h100);
    checkOutput("t2_opd2", out_alu_operand2, 32'd1);
    checkOutput("t2_dest", out_alu_dest_tag, 4'h4);
    checkOutput("t2_pred", out_alu_predicted_taken, 1'b1);

    $display("[TB] test 3: issue-time bypass");
    applyStimulus(1'b1, 6'h03, 4'h0, 32'd3, 4'h5, 32'hBEEF, 4'h6, 32'h1008, 32'h0, 1'b0);
    setCdb(1'b1, 4'h5, 32'd9);
    step();
    idle();
    step();
    checkOutput("t3_ena", out_alu_ena, 1'b1);
    checkOutput("t3_opd1", out_alu_operand1, 32'd3);
    checkOutput("t3_opd2", out_alu_operand2, 32'd9);
    checkOutput("t3_dest", out_alu_dest_tag, 4'h6);

    $display("[TB] test 4: fill, wake slot 3");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 6'h04, 4'(i + 1), 32'h0, 4'h0, 32'(i), 4'(8 + i), 32'h2000 + 32'(4 * i), 32'h0, 1'b0);
      step();
    end
    idle();
    checkOutput("t4_full", out_full, 1'b1);
    setCdb(1'b1, 4'h4, 32'h44);
    step();
    checkOutput("t4_still_full", out_full, 1'b1);
    checkOutput("t4_wait", out_alu_ena, 1'b0);
    idle();
    step();
    checkOutput("t4_ena", out_alu_ena, 1'b1);
    checkOutput("t4_opd1", out_alu_operand1, 32'h44);
    checkOutput("t4_opd2", out_alu_operand2, 32'd3);
    checkOutput("t4_dest", out_alu_dest_tag, 4'd11);
    checkOutput("t4_not_full", out_full, 1'b0);
    in_rollback = 1'b1;
    step();
    idle();
    checkOutput("t4_flush", out_full, 1'b0);

    $display("[TB] test 5: two slots ready together, lowest index first");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 6'h05, (i == 2 || i == 6) ? 4'h7 : 4'h1, 32'h0, 4'h0, 32'(16 * i),
                    4'(8 + i), 32'h2100 + 32'(4 * i), 32'h0, 1'b0);
      step();
    end
    idle();
    setCdb(1'b1, 4'h7, 32'h77);
    step();
    idle();
    applyStimulus(1'b1, 6'h06, 4'h0, 32'hAA, 4'h0, 32'hBB, 4'h3, 32'h2200, 32'h5, 1'b1);
    step();
    idle();
    checkOutput("t5_first_dest", out_alu_dest_tag, 4'd10);
    checkOutput("t5_first_opd1", out_alu_operand1, 32'h77);
    checkOutput("t5_first_opd2", out_alu_operand2, 32'h20);
    step();
    checkOutput("t5_second_ena", out_alu_ena, 1'b1);
    checkOutput("t5_second_dest", out_alu_dest_tag, 4'd14);
    checkOutput("t5_second_opd2", out_alu_operand2, 32'h60);
    step();
    checkOutput("t5_third_dest", out_alu_dest_tag, 4'd3);
    checkOutput("t5_third_opd1", out_alu_operand1, 32'hAA);
    step();
    checkOutput("t5_drained", out_alu_ena, 1'b0);
    in_rollback = 1'b1;
    step();
    idle();

    $display("[TB] test 6: rollback beats issue and dispatch");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 6'h07, 4'h9, 32'h0, 4'h0, 32'h0, 4'(i), 32'h2300, 32'h0, 1'b0);
      step();
    end
    applyStimulus(1'b1, 6'h08, 4'h0, 32'h1, 4'h0, 32'h2, 4'd12, 32'h2400, 32'h0, 1'b0);
    step();
    applyStimulus(1'b1, 6'h09, 4'h0, 32'h3, 4'h0, 32'h4, 4'd13, 32'h2500, 32'h0, 1'b0);
    in_rollback = 1'b1;
    step();
    idle();
    checkOutput("t6_ena", out_alu_ena, 1'b0);
    checkOutput("t6_full", out_full, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("t6_quiet", out_alu_ena, 1'b0);
    end
    applyStimulus(1'b1, 6'h0A, 4'h0, 32'h11, 4'h0, 32'h22, 4'd1, 32'h3000, 32'h0, 1'b0);
    step();
    idle();
    step();
    checkOutput("t6_reissue_ena", out_alu_ena, 1'b1);
    checkOutput("t6_reissue_dest", out_alu_dest_tag, 4'd1);

    $display("[TB] test 7: asynchronous reset mid-operation");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 6'h0B, 4'h2, 32'h0, 4'h0, 32'h0, 4'd5, 32'h3100, 32'h0, 1'b0);
      step();
    end
    idle();
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t7_rst_pc", out_alu_pc, 32'h0);
    checkOutput("t7_rst_dest", out_alu_dest_tag, 4'h0);
    checkOutput("t7_rst_opd1", out_alu_operand1, 32'h0);
    step();
    rst = 1'b0;
    step();
    applyStimulus(1'b1, 6'h0C, 4'h0, 32'h5, 4'h0, 32'h6, 4'd7, 32'h3200, 32'h0, 1'b0);
    step();
    idle();
    step();
    checkOutput("t7_after_ena", out_alu_ena, 1'b1);
    checkOutput("t7_after_dest", out_alu_dest_tag, 4'd7);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
